pdm_frame_loader: RTL and testbench
===================================

Name: pdm_frame_loader

Overview:
- Upstream feeder for the 8-point radix-2 `fft` core.
- Takes the 1-bit PDM microphone stream (one bit per `sample_en` strobe, already sampled in the `clk` domain) and decimates it with a box (ones-count) filter into Q16.16 signed samples.
- Packs N_PTS consecutive samples into a double-buffered frame and presents it to the FFT with a valid/ready handshake. Imaginary inputs of the FFT are tied to zero outside this block.

Parameters:
- DECIM, 16, PDM bits per output sample; power of 2, 2..2^FRAC_W.
- N_PTS, 8, samples per frame (FFT size).
- DATA_W, 32, sample word width (Q16.16 two's complement).
- FRAC_W, 16, fractional bits of the sample word.

Ports:
- clk  input  1  system clock (100 MHz).
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  loader enable; low discards the partial frame.
- sample_en  input  1  one-cycle strobe: `sample_bit` is valid this cycle.
- sample_bit  input  1  PDM microphone bit.
- frame_data  output  N_PTS*DATA_W  sample k at [k*DATA_W +: DATA_W]; k=0 is the oldest sample.
- frame_valid  output  1  frame_data holds an undelivered frame.
- frame_ready  input  1  FFT accepts the frame when high together with `frame_valid`.
- overrun  output  1  one-cycle pulse: a completed frame was dropped.
- frame_seq  output  8  count of delivered frames, wraps at 255.

Behaviour:
- Reset (async assert, sync release) clears all state:
  - frame_data=0, frame_valid=0, overrun=0, frame_seq=0.
  - ones accumulator=0, bit counter=0, sample index=0.
- Decimator, per accepted strobe (`en`=1 and `sample_en`=1):
  - ones += `sample_bit`; bitcnt += 1.
  - When bitcnt reaches DECIM: sample = (2*ones - DECIM) << (FRAC_W - log2(DECIM)), sign-extended to DATA_W. It is written into the fill bank at the sample index; ones and bitcnt clear in the same cycle.
  - Range is exactly -1.0 (0xFFFF0000) to +1.0 (0x00010000). No saturation is needed.
- Fill bank:
  - Sample index counts 0..N_PTS-1.
  - Writing index N_PTS-1 completes the frame; the index wraps to 0.
- Output FSM, states EMPTY and FULL. Frame completion occurs at cycle t; every transition is registered.
  - EMPTY and frame completes at t: copy fill bank into output bank; frame_valid=1 at t+1.
  - FULL and `frame_ready`=1 at t: handshake. frame_valid=0 at t+1; frame_seq+1 at t+1.
  - FULL, handshake and completion both at t: new frame loaded; frame_valid stays 1; frame_seq+1. No drop.
  - FULL, no handshake, completion at t: frame discarded; output bank unchanged; overrun=1 for exactly cycle t+1.
- frame_data is stable while frame_valid=1 and there has been no handshake.
- frame_data keeps its last value after delivery; the consumer must not rely on it.
- `en` low:
  - Strobes are ignored.
  - Accumulator, bitcnt and sample index clear on the next clk edge.
  - Output bank and FSM are unaffected; a pending frame can still be accepted.
- `sample_en` with `en` rising in the same cycle: the strobe is accepted and counted as bit 0.
- Latency: the last PDM bit of a frame is accepted at cycle t; frame_valid=1 at t+1 (if EMPTY).
- Reset mid-frame: partial data is lost and no overrun pulses. Release restarts at bit 0, sample 0.

Decomposition:
- Shared package `fft_pkg`:
  - Constants: DATA_W=32, FRAC_W=16, N_PTS=8, Q16.16 ONE=32'h0001_0000.
  - Typedef `sample_t` (signed [31:0]).
  - Function clog2.
  - The same package is used by `fft`/`ifft`.
- One sub-module, `pdm_box_decim`:
  - Function: ones accumulator, bit counter, scaling.
  - Outputs: `dec_valid` pulse and `dec_sample`.
- Frame buffer and output FSM stay in the top.

Test Plan:
- All-ones PDM: 128 strobes, ready=1 → after strobe 128, frame_valid=1 for 1 cycle; all 8 words 0x00010000; frame_seq=1.
- Alternating 1010… PDM: 128 strobes → all words 0x00000000.
- Ramp: sample k uses k*2 ones per 16 bits (k=0..7) → word k = (4k-16)<<12, e.g. k=0 0xFFFF0000, k=4 0x00000000, k=7 0x0000C000.
- Ready held 0 for 256 strobes → overrun pulses once at strobe 256 (+1 cycle); frame_data still holds frame 1; frame_seq=0. Then ready=1 → frame_seq=1, frame_valid=0.
- Ready asserted on the exact cycle the second frame completes → frame_valid stays 1; frame_data switches to frame 2; frame_seq increments; no overrun.
- `en` dropped after 70 strobes, re-raised, then 128 all-zero strobes → frame of 8×0xFFFF0000 with no residue. Then assert `rst_n`=0 mid-frame asynchronously → all outputs 0 immediately.

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fft_pkg
//  Brief    : Shared constants, sample type and helpers for the FFT datapath.
//  Revision : 1.0
// ============================================================================
package fft_pkg;

    localparam int          DATA_W = 32;
    localparam int          FRAC_W = 16;
    localparam int          N_PTS  = 8;
    localparam logic [31:0] ONE    = 32'h0001_0000;

    typedef logic signed [31:0] sample_t;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } loader_state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pdm_frame_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : pdm_frame_loader_if
//  Brief    : Frame handshake bundle between the PDM loader and the FFT core.
//  Revision : 1.0
// ============================================================================
interface pdm_frame_loader_if #(
    parameter int N_PTS  = 8,
    parameter int DATA_W = 32
) ();

    logic [N_PTS*DATA_W-1:0] frame_data;
    logic                    frame_valid;
    logic                    frame_ready;
    logic                    overrun;
    logic [7:0]              frame_seq;

    modport master (
        output frame_data,
        output frame_valid,
        input  frame_ready,
        output overrun,
        output frame_seq
    );

    modport slave (
        input  frame_data,
        input  frame_valid,
        output frame_ready,
        input  overrun,
        input  frame_seq
    );

endinterface
`default_nettype wire

// File: rtl/pdm_frame_loader_box_decim.sv
`default_nettype none
// ============================================================================
//  Module   : pdm_box_decim
//  Brief    : Ones-count box decimator, PDM bits to Q-format signed samples.
//  Revision : 1.0
// ============================================================================
module pdm_box_decim #(
    parameter int DECIM  = 16,
    parameter int DATA_W = fft_pkg::DATA_W,
    parameter int FRAC_W = fft_pkg::FRAC_W
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              en,
    input  wire logic              sample_en,
    input  wire logic              sample_bit,
    output logic                   dec_valid,
    output logic [DATA_W-1:0]      dec_sample
);
    import fft_pkg::*;

    localparam int LOG2_DECIM = clog2(DECIM);
    localparam int CNT_W      = LOG2_DECIM + 1;
    localparam int SHIFT      = FRAC_W - LOG2_DECIM;
    localparam logic [DATA_W-1:0] C_DECIM = DATA_W'(DECIM);

    logic [CNT_W-1:0]  r_ones;
    logic [CNT_W-1:0]  r_bitcnt;
    logic              w_accept;
    logic              w_last;
    logic [CNT_W-1:0]  w_ones_total;
    logic [DATA_W-1:0] w_sum;

    assign w_accept     = en & sample_en;
    assign w_ones_total = r_ones + CNT_W'(sample_bit);
    assign w_last       = w_accept && (r_bitcnt == CNT_W'(DECIM - 1));

    // Sample goes out in the same cycle as the closing bit so the frame
    // completes without an extra pipeline stage; modulo arithmetic yields
    // the two's-complement result directly.
    assign w_sum      = {{(DATA_W-CNT_W){1'b0}}, w_ones_total};
    assign dec_sample = ((w_sum << 1) - C_DECIM) << SHIFT;
    assign dec_valid  = w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ones   <= '0;
            r_bitcnt <= '0;
        end else if (!en) begin
            r_ones   <= '0;
            r_bitcnt <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_ones   <= '0;
                r_bitcnt <= '0;
            end else begin
                r_ones   <= w_ones_total;
                r_bitcnt <= r_bitcnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pdm_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module   : pdm_frame_loader
//  Brief    : PDM decimator plus double-buffered frame loader feeding the FFT.
//  Revision : 1.0
// ============================================================================
module pdm_frame_loader #(
    parameter int DECIM  = 16,
    parameter int N_PTS  = fft_pkg::N_PTS,
    parameter int DATA_W = fft_pkg::DATA_W,
    parameter int FRAC_W = fft_pkg::FRAC_W
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            en,
    input  wire logic            sample_en,
    input  wire logic            sample_bit,
    pdm_frame_loader_if.master   fr
);
    import fft_pkg::*;

    localparam int IDX_W = clog2(N_PTS);

    logic                    w_dec_valid;
    logic [DATA_W-1:0]       w_dec_sample;
    logic [DATA_W-1:0]       r_fill [N_PTS];
    logic [IDX_W-1:0]        r_idx;
    logic [N_PTS*DATA_W-1:0] r_out_bank;
    logic [N_PTS*DATA_W-1:0] w_frame_new;
    logic [7:0]              r_seq;
    logic                    r_overrun;
    loader_state_t           r_state;
    loader_state_t           w_state_next;
    logic                    w_complete;
    logic                    w_load;
    logic                    w_seq_inc;
    logic                    w_drop;

    pdm_box_decim #(
        .DECIM  (DECIM),
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_decim (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .sample_en  (sample_en),
        .sample_bit (sample_bit),
        .dec_valid  (w_dec_valid),
        .dec_sample (w_dec_sample)
    );

    assign w_complete = w_dec_valid && (r_idx == IDX_W'(N_PTS - 1));

    // The completing sample is still in flight, so splice it into the copy.
    generate
        for (genvar k = 0; k < N_PTS; k++) begin : g_frame
            if (k == N_PTS - 1) begin : g_last
                assign w_frame_new[k*DATA_W +: DATA_W] = w_dec_sample;
            end else begin : g_fill
                assign w_frame_new[k*DATA_W +: DATA_W] = r_fill[k];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
            for (int k = 0; k < N_PTS; k++) begin
                r_fill[k] <= '0;
            end
        end else if (!en) begin
            r_idx <= '0;
        end else if (w_dec_valid) begin
            r_fill[r_idx] <= w_dec_sample;
            r_idx         <= w_complete ? '0 : r_idx + IDX_W'(1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_seq_inc    = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_complete) begin
                    w_load       = 1'b1;
                    w_state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (fr.frame_ready) begin
                    w_seq_inc = 1'b1;
                    if (w_complete) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next = ST_EMPTY;
                    end
                end else if (w_complete) begin
                    w_drop = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_out_bank <= '0;
            r_seq      <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_overrun <= w_drop;
            if (w_load) begin
                r_out_bank <= w_frame_new;
            end
            if (w_seq_inc) begin
                r_seq <= r_seq + 8'd1;
            end
        end
    end

    assign fr.frame_data  = r_out_bank;
    assign fr.frame_valid = (r_state == ST_FULL);
    assign fr.overrun     = r_overrun;
    assign fr.frame_seq   = r_seq;

endmodule
`default_nettype wire

// File: tb/tb_pdm_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pdm_frame_loader
//  Brief    : Directed and randomized bench for pdm_frame_loader.
//  Revision : 1.0
// ============================================================================
module tb_pdm_frame_loader;

    localparam int DECIM  = 16;
    localparam int N_PTS  = 8;
    localparam int DATA_W = 32;
    localparam int FW     = N_PTS * DATA_W;

    logic clk;
    logic rst_n;
    logic en;
    logic sample_en;
    logic sample_bit;

    pdm_frame_loader_if #(.N_PTS(N_PTS), .DATA_W(DATA_W)) fif ();

    pdm_frame_loader #(
        .DECIM  (DECIM),
        .N_PTS  (N_PTS),
        .DATA_W (DATA_W),
        .FRAC_W (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .sample_en  (sample_en),
        .sample_bit (sample_bit),
        .fr         (fif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a bit tally per sample, a list of finished samples,
    // and the consumer-visible frame slot.
    int          m_cnt;
    int          m_ones;
    int          m_nsamp;
    logic [31:0] m_samp [N_PTS];
    logic        m_valid;
    logic        m_overrun;
    logic [7:0]  m_seq;
    logic [FW-1:0] m_data;

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_ones = 0; m_nsamp = 0;
        m_valid = 1'b0; m_overrun = 1'b0; m_seq = 8'd0; m_data = '0;
        for (int k = 0; k < N_PTS; k++) m_samp[k] = '0;
    endtask

    task automatic model_cycle(input logic e, input logic s, input logic b, input logic r);
        logic          complete;
        logic [FW-1:0] frame;
        int            v;
        complete = 1'b0;
        frame    = '0;
        if (!e) begin
            m_cnt = 0; m_ones = 0; m_nsamp = 0;
        end else if (s) begin
            m_cnt++;
            m_ones += int'(b);
            if (m_cnt == DECIM) begin
                // value in [-1,+1] is (2*ones-DECIM)/DECIM, scaled to Q16.16
                v = ((2 * m_ones - DECIM) * 65536) / DECIM;
                m_samp[m_nsamp] = 32'(v);
                m_nsamp++;
                m_cnt = 0; m_ones = 0;
                if (m_nsamp == N_PTS) begin
                    complete = 1'b1;
                    m_nsamp  = 0;
                    for (int k = 0; k < N_PTS; k++) frame[k*DATA_W +: DATA_W] = m_samp[k];
                end
            end
        end
        m_overrun = 1'b0;
        if (m_valid && r) begin
            m_seq = m_seq + 8'd1;
            if (complete) m_data = frame;
            else          m_valid = 1'b0;
        end else if (complete) begin
            if (m_valid) m_overrun = 1'b1;
            else begin
                m_data  = frame;
                m_valid = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"},   FW'(fif.frame_valid), FW'(m_valid));
        chk({tag, ".overrun"}, FW'(fif.overrun),     FW'(m_overrun));
        chk({tag, ".seq"},     FW'(fif.frame_seq),   FW'(m_seq));
        chk({tag, ".data"},    fif.frame_data,       m_data);
    endtask

    task automatic step(input logic e, input logic s, input logic b, input logic r);
        en = e; sample_en = s; sample_bit = b; fif.frame_ready = r;
        model_cycle(e, s, b, r);
        @(posedge clk);
        #1;
        check_all("step");
    endtask

    logic [FW-1:0] exp_frame;
    logic [FW-1:0] saved_frame;
    logic [7:0]    seq_before;
    int            ovr_pulses;

    initial begin
        rst_n = 1'b0; en = 1'b0; sample_en = 1'b0; sample_bit = 1'b0;
        fif.frame_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset.valid",   FW'(fif.frame_valid), '0);
        chk("reset.overrun", FW'(fif.overrun),     '0);
        chk("reset.seq",     FW'(fif.frame_seq),   '0);
        chk("reset.data",    fif.frame_data,       '0);
        #2 rst_n = 1'b1;

        // All-ones frame with the consumer always ready
        for (int i = 0; i < 128; i++) step(1, 1, 1, 1);
        exp_frame = {N_PTS{32'h0001_0000}};
        chk("ones.valid", FW'(fif.frame_valid), FW'(1));
        chk("ones.data",  fif.frame_data, exp_frame);
        step(1, 0, 0, 1);
        chk("ones.seq",   FW'(fif.frame_seq), FW'(1));
        chk("ones.drain", FW'(fif.frame_valid), FW'(0));

        // Alternating pattern gives zero in every word
        for (int i = 0; i < 128; i++) step(1, 1, logic'(i % 2), 0);
        chk("alt.data", fif.frame_data, '0);
        step(1, 0, 0, 1);
        chk("alt.seq", FW'(fif.frame_seq), FW'(2));

        // Ramp: sample k carries 2k ones out of 16
        for (int k = 0; k < N_PTS; k++)
            for (int j = 0; j < DECIM; j++) step(1, 1, logic'(j < 2 * k), 0);
        for (int k = 0; k < N_PTS; k++) exp_frame[k*DATA_W +: DATA_W] = 32'((4 * k - 16) * 4096);
        chk("ramp.data", fif.frame_data, exp_frame);
        chk("ramp.w0",   FW'(fif.frame_data[31:0]),    FW'(32'hFFFF_0000));
        chk("ramp.w7",   FW'(fif.frame_data[255:224]), FW'(32'h0000_C000));
        step(1, 0, 0, 1);

        // Consumer stalls across two frames: second one is dropped
        ovr_pulses = 0;
        seq_before = m_seq;
        for (int i = 0; i < 256; i++) begin
            step(1, 1, logic'($urandom_range(0, 1)), 0);
            if (i == 127) saved_frame = m_data;
            if (fif.overrun) ovr_pulses++;
        end
        step(1, 0, 0, 0);
        if (fif.overrun) ovr_pulses++;
        chk("ovr.pulses", FW'(ovr_pulses), FW'(1));
        chk("ovr.hold",   fif.frame_data, saved_frame);
        chk("ovr.seq",    FW'(fif.frame_seq), FW'(seq_before));
        step(1, 0, 0, 1);
        chk("ovr.seq1",   FW'(fif.frame_seq), FW'(seq_before + 8'd1));
        chk("ovr.valid",  FW'(fif.frame_valid), FW'(0));

        // Handshake on the very cycle the next frame completes
        for (int i = 0; i < 128; i++) step(1, 1, logic'($urandom_range(0, 1)), 0);
        seq_before = m_seq;
        for (int i = 0; i < 127; i++) step(1, 1, logic'($urandom_range(0, 1)), 0);
        step(1, 1, 1, 1);
        chk("swap.valid",   FW'(fif.frame_valid), FW'(1));
        chk("swap.overrun", FW'(fif.overrun), FW'(0));
        chk("swap.seq",     FW'(fif.frame_seq), FW'(seq_before + 8'd1));
        chk("swap.data",    fif.frame_data, m_data);
        step(1, 0, 0, 1);

        // Enable drop discards the partial frame
        for (int i = 0; i < 70; i++) step(1, 1, 1, 0);
        repeat (3) step(0, 1, 1, 0);
        for (int i = 0; i < 128; i++) step(1, 1, 0, 0);
        exp_frame = {N_PTS{32'hFFFF_0000}};
        chk("en.data", fif.frame_data, exp_frame);
        step(1, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 1200; i++)
            step(logic'($urandom_range(0, 15) != 0), logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) == 0));
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Asynchronous reset with a frame pending and another half loaded
        for (int i = 0; i < 168; i++) step(1, 1, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("areset.valid",   FW'(fif.frame_valid), '0);
        chk("areset.seq",     FW'(fif.frame_seq),   '0);
        chk("areset.data",    fif.frame_data,       '0);
        chk("areset.overrun", FW'(fif.overrun),     '0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 128; i++) step(1, 1, 1, 0);
        exp_frame = {N_PTS{32'h0001_0000}};
        chk("restart.data",  fif.frame_data, exp_frame);
        chk("restart.valid", FW'(fif.frame_valid), FW'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
